// File: rtl/ps2_command_decoder.sv
// PS/2 keyboard frame receiver and game-command decoder.
// Optional parity check: define PS2_PARITY_CHECK_EN.
module ps2_command_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] keyboard_signal,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]    sclk_q, sdat_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          strobe_q, strobe_d;
  logic          err_q, err_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [2:0]    kbd_q, kbd_d;

  logic sclk, sdat, fall, frame_ok;

  assign sclk = sclk_q[1];
  assign sdat = sdat_q[1];
  assign fall = filt_q & ~filt_d;
  assign frame_ok = sdat &
    (~PAR_CHK | (^{shift_q, par_q}));

  assign keyboard_signal = kbd_q;
  assign frame_err       = err_q;

  function automatic logic [2:0] cmd_map(
    input logic       e,
    input logic [7:0] b
  );
    logic [2:0] c;
    c = 3'b000;
    unique case (1'b1)
      (e && b == 8'h72),
      (!e && b == 8'h1B): c = 3'b100;
      (e && b == 8'h6B),
      (!e && b == 8'h1C): c = 3'b101;
      (e && b == 8'h74),
      (!e && b == 8'h23): c = 3'b110;
      (e && b == 8'h75),
      (!e && b == 8'h1D): c = 3'b111;
      default:            c = 3'b000;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q   <= 2'b11;
      sdat_q   <= 2'b11;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      bcnt_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      kbd_q    <= 3'b000;
    end else begin
      sclk_q   <= {sclk_q[0], ps2_clk};
      sdat_q   <= {sdat_q[0], ps2_data};
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tcnt_q   <= tcnt_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      kbd_q    <= kbd_d;
    end
  end

  // Level changes only after FILTER_LEN differing samples in a row.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sclk != filt_q) begin
      if (fcnt_q == FLAST) filt_d = sclk;
      else fcnt_d = fcnt_q + FW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    if (state_q == IDLE || fall) tcnt_d = '0;
    else tcnt_d = tcnt_q + TW'(1);
    unique case (state_q)
      IDLE: begin
        if (fall && !sdat) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {sdat, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = sdat;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d  = IDLE;
          strobe_d = frame_ok;
          err_d    = ~frame_ok;
        end
      end
      default: state_d = IDLE;
    endcase
    // Stalled partial frame: abandon it.
    if (state_q != IDLE && !fall &&
        tcnt_q == TLAST) begin
      state_d = IDLE;
      bcnt_d  = '0;
      tcnt_d  = '0;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    kbd_d = 3'b000;
    if (strobe_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!brk_q) kbd_d = cmd_map(ext_q, shift_q);
      end
    end
  end

endmodule

// File: doc/ps2_command_decoder.md
PS2_COMMAND_DECODER -- requirements
Module: ps2_command_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive identical synchronized samples required before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: clk cycles without a filtered PS/2 falling edge before a partial frame is abandoned.
REQ-003 Port clk  input  1  system clock; all logic SHALL run on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 Port ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 Port keyboard_signal  output  3  game command pulse: 000 idle, 100 down, 101 left, 110 right, 111 rotate.
REQ-008 Port frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-010 Filtered clock SHALL take the synchronized ps2_clk level only after FILTER_LEN consecutive equal samples; shorter glitches SHALL be ignored.
REQ-011 A bit SHALL be sampled from synchronized ps2_data in the clk cycle a filtered 1->0 transition is detected.
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: sampled 0 -> DATA; sampled 1 -> stay IDLE, no error.
- DATA: 8 bits, LSB first, bit counter 0..7; after bit 7 -> PARITY.
- PARITY: capture bit -> STOP.
- STOP: -> IDLE.
REQ-013 Frame valid: stop bit = 1 and (REQ-024) odd parity over data+parity bits; valid frames SHALL assert an internal byte strobe for one cycle, the cycle after the stop-bit sample.
REQ-014 Invalid frame: byte dropped, frame_err = 1 for exactly one cycle, the cycle after the stop-bit sample.
REQ-015 Outside IDLE, TIMEOUT_CYCLES cycles with no filtered falling edge SHALL force IDLE, pulse frame_err once, discard partial bits; the counter SHALL clear on every falling edge and in IDLE.
REQ-016 Byte layer flags ext and brk, both 0 after reset:
- 0xE0 sets ext; 0xF0 sets brk; neither emits a command.
- Any other byte SHALL clear both flags in the same cycle it is decoded.
REQ-017 Command map, evaluated only when brk = 0:
- ext = 1: 0x72 -> 100, 0x6B -> 101, 0x74 -> 110, 0x75 -> 111.
- ext = 0: 0x1B -> 100, 0x1C -> 101, 0x23 -> 110, 0x1D -> 111.
- All other codes, and any code with brk = 1: no command.
REQ-018 keyboard_signal SHALL carry the mapped code for exactly one clk cycle, the cycle after the byte strobe, i.e. 2 cycles after stop-bit sampling; otherwise 000.
REQ-019 Keyboard typematic repeats of a make code SHALL each produce one pulse; no internal auto-repeat.
REQ-020 frame_err and keyboard_signal SHALL never be non-zero in the same cycle, since an invalid frame emits no command.

Reset
REQ-021 Asserting rst SHALL, asynchronously and mid-frame included, force FSM IDLE, bit counter 0, timeout counter 0, ext = brk = 0, synchronizers and filtered clock 1, filter counter 0.
REQ-022 Reset values: keyboard_signal = 000, frame_err = 0.
REQ-023 After deassertion, decoding SHALL resume on the next start bit; no pre-reset state SHALL affect later output.

Configuration
REQ-024 Macro PS2_PARITY_CHECK_EN, when defined: a parity mismatch SHALL invalidate the frame per REQ-014.
- Not defined: parity bit sampled but ignored; only a stop bit of 0 invalidates a frame.

Verification
REQ-025 Frames E0, 6B at 10 kHz PS/2 clock -> keyboard_signal = 101 for exactly 1 cycle, 2 cycles after the last stop sample; 000 otherwise.
REQ-026 Frames E0, F0, 75 -> keyboard_signal stays 000; then 1D -> single 111 pulse.
REQ-027 Frame 1C with wrong parity, macro defined -> frame_err = 1 for 1 cycle, no 101. Macro undefined -> single 101, frame_err = 0.
REQ-028 Start bit plus 4 data bits, then idle TIMEOUT_CYCLES+1 cycles -> one frame_err pulse; next valid 23 -> single 110.
REQ-029 Frame E0, then rst asserted mid-way through the next frame, then frame 6B -> no command, since ext was cleared; then 1B -> single 100.
REQ-030 ps2_clk low glitches of FILTER_LEN-1 cycles injected inside a valid 72 frame preceded by E0 -> single 100, frame_err = 0.
